// File: rtl/cdc_evt_pkg.sv
// Shared types and helpers for the synchronized-event scheduler.
package cdc_evt_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } evt_state_e;

   // A one-channel build still needs a 1-bit id.
   function automatic int id_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/cdc_evt_rr.sv
// Combinational round-robin pick: first requesting channel at or after ptr_i, wrapping.
module cdc_evt_rr
   import cdc_evt_pkg::*;
#(
   parameter int CH_NUM = 4,
   localparam int IDW = id_width(CH_NUM)
) (
   input  logic [CH_NUM-1:0] req_i,
   input  logic [IDW-1:0]    ptr_i,
   output logic [IDW-1:0]    gnt_o,
   output logic              any_o
);

   logic           hi_any;
   logic [IDW-1:0] hi_idx;
   logic [IDW-1:0] lo_idx;

   // Descending scan so the last hit is the lowest index: hi_* covers [ptr..top], lo_* the wrap.
   always_comb begin
      hi_any = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int c = CH_NUM - 1; c >= 0; c--) begin
         if (req_i[c]) begin
            lo_idx = IDW'(c);
            if (c >= int'(ptr_i)) begin
               hi_any = 1'b1;
               hi_idx = IDW'(c);
            end
         end
      end
   end

   assign any_o = |req_i;
   assign gnt_o = hi_any ? hi_idx : lo_idx;

endmodule

// File: rtl/cdc_evt_arb.sv
// Turns synchronized toggles into per-channel pending counts and serves them round-robin
// on one valid/ready event port.
module cdc_evt_arb
   import cdc_evt_pkg::*;
#(
   parameter int CH_NUM    = 4,
   parameter int CNT_WIDTH = 2,
   localparam int IDW = id_width(CH_NUM)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [CH_NUM-1:0] sync_pre_i,
   input  logic [CH_NUM-1:0] sync_i,
   input  logic [CH_NUM-1:0] en_i,
   output logic              evt_valid_o,
   input  logic              evt_ready_i,
   output logic [IDW-1:0]    evt_id_o,
   output logic [CH_NUM-1:0] ovf_o,
   input  logic [CH_NUM-1:0] ovf_clr_i
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
   localparam logic [IDW-1:0]       LAST_CH = IDW'(CH_NUM - 1);

   evt_state_e                       state_q;
   logic [CH_NUM-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic [CH_NUM-1:0]                ovf_q, ovf_d;
   logic [CH_NUM-1:0]                req, evt_edge, take;
   logic [IDW-1:0]                   rr_ptr_q, evt_id_q, gnt, nxt_ptr;
   logic                             evt_valid_q, any_req, take_en;

   assign evt_edge = en_i & (sync_pre_i ^ sync_i);

   always_comb begin
      for (int c = 0; c < CH_NUM; c++) begin
         req[c] = |cnt_q[c];
      end
   end

   cdc_evt_rr #(.CH_NUM(CH_NUM)) u_rr (
      .req_i (req),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .any_o (any_req)
   );

   // A channel is taken whenever the offer slot is free or being emptied this cycle.
   assign take_en = any_req & ((state_q == IDLE) | evt_ready_i);
   assign nxt_ptr = (gnt == LAST_CH) ? '0 : gnt + IDW'(1);

   always_comb begin
      cnt_d = cnt_q;
      ovf_d = ovf_q & ~ovf_clr_i;
      take  = '0;
      for (int c = 0; c < CH_NUM; c++) begin
         take[c] = take_en & (gnt == IDW'(c));
         if (evt_edge[c] & ~take[c]) begin
            if (cnt_q[c] == CNT_MAX) begin
               ovf_d[c] = 1'b1;
            end else begin
               cnt_d[c] = cnt_q[c] + CNT_WIDTH'(1);
            end
         end else if (take[c] & ~evt_edge[c]) begin
            cnt_d[c] = cnt_q[c] - CNT_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q <= '0;
         ovf_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   // Valid/ready: once evt_valid_o rises, it and evt_id_o hold until evt_ready_i is seen.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         evt_valid_q <= 1'b0;
         evt_id_q    <= '0;
         rr_ptr_q    <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  state_q     <= OFFER;
                  evt_valid_q <= 1'b1;
                  evt_id_q    <= gnt;
                  rr_ptr_q    <= nxt_ptr;
               end
            end
            OFFER: begin
               if (evt_ready_i) begin
                  if (any_req) begin
                     evt_id_q <= gnt;
                     rr_ptr_q <= nxt_ptr;
                  end else begin
                     state_q     <= IDLE;
                     evt_valid_q <= 1'b0;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign evt_valid_o = evt_valid_q;
   assign evt_id_o    = evt_id_q;
   assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_cdc_evt_arb.sv
// Self-checking bench for cdc_evt_arb: vector table, corner sequences, random run vs model.
module tb_cdc_evt_arb;

   localparam int CH   = 4;
   localparam int CW   = 2;
   localparam int MAXC = (1 << CW) - 1;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic [3:0] sync_pre_i, sync_i, en_i, ovf_clr_i, ovf_o;
   logic       evt_valid_o, evt_ready_i;
   logic [1:0] evt_id_o;

   cdc_evt_arb #(.CH_NUM(CH), .CNT_WIDTH(CW)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .sync_pre_i  (sync_pre_i),
      .sync_i      (sync_i),
      .en_i        (en_i),
      .evt_valid_o (evt_valid_o),
      .evt_ready_i (evt_ready_i),
      .evt_id_o    (evt_id_o),
      .ovf_o       (ovf_o),
      .ovf_clr_i   (ovf_clr_i)
   );

   always #5 clk_i = ~clk_i;

   int         n_cmp;
   int         n_err;
   logic [1:0] exp_q[$];

   // Reference model: pending counts per channel, one offer slot, next-search pointer.
   int m_pend[CH];
   bit m_ovf[CH];
   int m_ptr;
   bit m_vld;
   int m_id;

   bit         last_hs;
   logic [1:0] last_hs_id;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < CH; c++) begin
         m_pend[c] = 0;
         m_ovf[c]  = 1'b0;
      end
      m_ptr = 0;
      m_vld = 1'b0;
      m_id  = 0;
      exp_q.delete();
   endtask

   function automatic logic [3:0] model_ovf();
      logic [3:0] v;
      for (int c = 0; c < CH; c++) v[c] = m_ovf[c];
      return v;
   endfunction

   task automatic model_step(input logic [3:0] pre, input logic [3:0] syn, input logic [3:0] en,
                             input logic [3:0] clr, input logic rdy);
      int  take_ch;
      int  n;
      int  e;
      take_ch = -1;
      if (m_vld && rdy) exp_q.push_back(2'(m_id));
      if (!m_vld || rdy) begin
         for (int k = 0; k < CH; k++) begin
            if (take_ch < 0 && m_pend[(m_ptr + k) % CH] > 0) take_ch = (m_ptr + k) % CH;
         end
      end
      if (take_ch >= 0) begin
         m_vld = 1'b1;
         m_id  = take_ch;
         m_ptr = (take_ch + 1) % CH;
      end else if (rdy) begin
         m_vld = 1'b0;
      end
      for (int c = 0; c < CH; c++) begin
         e = (en[c] && (pre[c] != syn[c])) ? 1 : 0;
         n = m_pend[c] + e - ((take_ch == c) ? 1 : 0);
         if (n > MAXC) begin
            m_pend[c] = MAXC;
            m_ovf[c]  = 1'b1;
         end else begin
            m_pend[c] = n;
            if (clr[c]) m_ovf[c] = 1'b0;
         end
      end
   endtask

   // One clock: drive at negedge, score any handshake, compare against the model after the edge.
   task automatic cycle(input logic r, input logic [3:0] pre, input logic [3:0] syn,
                        input logic [3:0] en, input logic [3:0] clr, input logic rdy);
      logic [1:0] got;
      @(negedge clk_i);
      rst_i       = r;
      sync_pre_i  = pre;
      sync_i      = syn;
      en_i        = en;
      ovf_clr_i   = clr;
      evt_ready_i = rdy;
      last_hs     = 1'b0;
      if (r) begin
         model_reset();
      end else begin
         model_step(pre, syn, en, clr, rdy);
         if (evt_valid_o && rdy) begin
            last_hs    = 1'b1;
            last_hs_id = evt_id_o;
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_unexpected: got id %0d expected no event at %0t", evt_id_o, $time);
            end else begin
               got = exp_q.pop_front();
               check("sb_id", 32'(evt_id_o), 32'(got));
            end
         end
      end
      @(posedge clk_i);
      #1;
      check("valid", 32'(evt_valid_o), 32'(m_vld));
      check("id", 32'(evt_id_o), 32'(m_id));
      check("ovf", 32'(ovf_o), 32'(model_ovf()));
   endtask

   typedef struct {
      logic       rst;
      logic [3:0] pre;
      logic [3:0] en;
      logic       rdy;
      logic       ev;
      logic [1:0] eid;
   } vec_t;

   vec_t tbl[20];

   initial begin
      int n_hs;
      n_cmp       = 0;
      n_err       = 0;
      rst_i       = 1'b1;
      sync_pre_i  = '0;
      sync_i      = '0;
      en_i        = '0;
      ovf_clr_i   = '0;
      evt_ready_i = 1'b0;
      model_reset();

      // rst, sync_pre (sync held 0), en, ready, expected valid, expected id
      tbl[0]  = '{1'b1, 4'b0000, 4'hF,    1'b1, 1'b0, 2'd0};
      tbl[1]  = '{1'b0, 4'b0100, 4'hF,    1'b1, 1'b0, 2'd0};
      tbl[2]  = '{1'b0, 4'b0000, 4'hF,    1'b1, 1'b1, 2'd2};
      tbl[3]  = '{1'b0, 4'b0000, 4'hF,    1'b1, 1'b0, 2'd2};
      tbl[4]  = '{1'b0, 4'b0000, 4'hF,    1'b1, 1'b0, 2'd2};
      tbl[5]  = '{1'b1, 4'b0000, 4'hF,    1'b1, 1'b0, 2'd0};
      tbl[6]  = '{1'b0, 4'b1011, 4'hF,    1'b1, 1'b0, 2'd0};
      tbl[7]  = '{1'b0, 4'b0000, 4'hF,    1'b1, 1'b1, 2'd0};
      tbl[8]  = '{1'b0, 4'b0000, 4'hF,    1'b1, 1'b1, 2'd1};
      tbl[9]  = '{1'b0, 4'b0000, 4'hF,    1'b1, 1'b1, 2'd3};
      tbl[10] = '{1'b0, 4'b0000, 4'hF,    1'b1, 1'b0, 2'd3};
      tbl[11] = '{1'b0, 4'b0001, 4'hF,    1'b1, 1'b0, 2'd3};
      tbl[12] = '{1'b0, 4'b0000, 4'hF,    1'b1, 1'b1, 2'd0};
      tbl[13] = '{1'b0, 4'b0000, 4'hF,    1'b1, 1'b0, 2'd0};
      tbl[14] = '{1'b0, 4'b0001, 4'b1110, 1'b1, 1'b0, 2'd0};
      tbl[15] = '{1'b0, 4'b0000, 4'b1110, 1'b1, 1'b0, 2'd0};
      tbl[16] = '{1'b0, 4'b0001, 4'hF,    1'b0, 1'b0, 2'd0};
      tbl[17] = '{1'b0, 4'b0000, 4'b1110, 1'b0, 1'b1, 2'd0};
      tbl[18] = '{1'b0, 4'b0000, 4'b1110, 1'b0, 1'b1, 2'd0};
      tbl[19] = '{1'b0, 4'b0000, 4'b1110, 1'b1, 1'b0, 2'd0};

      for (int i = 0; i < 20; i++) begin
         cycle(tbl[i].rst, tbl[i].pre, 4'b0000, tbl[i].en, 4'b0000, tbl[i].rdy);
         check($sformatf("tbl%0d_valid", i), 32'(evt_valid_o), 32'(tbl[i].ev));
         check($sformatf("tbl%0d_id", i), 32'(evt_id_o), 32'(tbl[i].eid));
      end

      // Saturation: five toggles on ch1 with ready low; the fifth overflows.
      cycle(1'b1, 4'b0000, 4'b0000, 4'hF, 4'b0000, 1'b0);
      for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0010, 4'b0000, 4'hF, 4'b0000, 1'b0);
      check("ovf_before_sat", 32'(ovf_o), 32'h0);
      cycle(1'b0, 4'b0010, 4'b0000, 4'hF, 4'b0000, 1'b0);
      check("ovf_set", 32'(ovf_o), 32'h2);
      check("sat_valid", 32'(evt_valid_o), 32'h1);
      check("sat_id", 32'(evt_id_o), 32'h1);
      n_hs = 0;
      for (int i = 0; i < 8; i++) begin
         cycle(1'b0, 4'b0000, 4'b0000, 4'hF, 4'b0000, 1'b1);
         if (last_hs && last_hs_id == 2'd1) n_hs++;
      end
      check("sat_delivered", 32'(n_hs), 32'd4);
      check("sat_drained", 32'(evt_valid_o), 32'h0);

      // Overflow set beats a simultaneous clear; a lone clear takes effect next cycle.
      for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0010, 4'b0000, 4'hF, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0010, 4'b0000, 4'hF, 4'b0010, 1'b0);
      check("ovf_set_wins", 32'(ovf_o[1]), 32'h1);
      cycle(1'b0, 4'b0000, 4'b0000, 4'hF, 4'b0010, 1'b0);
      check("ovf_cleared", 32'(ovf_o[1]), 32'h0);
      for (int i = 0; i < 8; i++) cycle(1'b0, 4'b0000, 4'b0000, 4'hF, 4'b0000, 1'b1);

      // Asynchronous reset in the middle of an offer on ch3.
      cycle(1'b1, 4'b0000, 4'b0000, 4'hF, 4'b0000, 1'b0);
      cycle(1'b0, 4'b1000, 4'b0000, 4'hF, 4'b0000, 1'b0);
      cycle(1'b0, 4'b0000, 4'b0000, 4'hF, 4'b0000, 1'b0);
      check("pre_rst_valid", 32'(evt_valid_o), 32'h1);
      check("pre_rst_id", 32'(evt_id_o), 32'h3);
      @(negedge clk_i);
      #2;
      rst_i = 1'b1;
      #1;
      check("async_valid", 32'(evt_valid_o), 32'h0);
      check("async_id", 32'(evt_id_o), 32'h0);
      model_reset();
      cycle(1'b1, 4'b0000, 4'b0000, 4'hF, 4'b0000, 1'b1);
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 4'b0000, 4'b0000, 4'hF, 4'b0000, 1'b1);
         check("post_rst_quiet", 32'(evt_valid_o), 32'h0);
      end

      // Random traffic against the model.
      cycle(1'b1, 4'b0000, 4'b0000, 4'hF, 4'b0000, 1'b0);
      for (int i = 0; i < 600; i++) begin
         logic [3:0] r_pre, r_syn, r_en, r_clr;
         logic       r_rdy;
         r_pre = 4'($urandom_range(0, 15));
         r_syn = 4'($urandom_range(0, 15));
         r_en  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
         r_clr = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
         r_rdy = ($urandom_range(0, 3) != 0);
         cycle(1'b0, r_pre, r_syn, r_en, r_clr, r_rdy);
      end
      for (int i = 0; i < 20; i++) cycle(1'b0, 4'b0000, 4'b0000, 4'hF, 4'b0000, 1'b1);
      check("final_idle", 32'(evt_valid_o), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
